pe_context_seq: RTL and testbench

//  Per-PE context sequencer sitting directly upstream of the PE `inst` port.

---
 rtl/pe_context_seq_pkg.sv | 8 +
 rtl/pe_context_seq_ctx_mem.sv | 26 ++
 rtl/pe_context_seq.sv | 110 +++++++++++
 tb/tb_pe_context_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_context_seq_pkg.sv
// pe_context_seq_pkg: shared widths, NOP encoding and FSM state encodings for the context sequencer
package pe_context_seq_pkg;
  localparam int PE_INST_W  = 48;
  localparam int CTX_DEPTH  = 16;
  localparam int CTX_ITER_W = 16;
  localparam logic [PE_INST_W-1:0] NOP = '0;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/pe_context_seq_ctx_mem.sv
// pe_context_seq_ctx_mem: DEPTH x INST_W context store, one write port, one async read port, no reset
//   clk   in   clock
//   we    in   write strobe
//   waddr in   write slot
//   wdata in   write word
//   raddr in   read slot
//   rdata out  word at raddr (combinational)
module pe_context_seq_ctx_mem
  import pe_context_seq_pkg::*;
#(
  parameter int INST_W = PE_INST_W,
  parameter int DEPTH  = CTX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pe_context_seq.sv
// pe_context_seq: per-PE context sequencer issuing contexts 0..last for a number of iterations
//   clk, rst      clock, synchronous active-low reset
//   cfg_we/addr/wdata  context write port, honoured in IDLE only
//   start, ctx_last, iter_cnt  run request and its parameters (latched on start)
//   stall, abort  freeze issue / terminate run without done
//   inst, inst_valid  issued context (NOP when not valid)
//   busy, done    run in progress / one-cycle completion pulse
module pe_context_seq
  import pe_context_seq_pkg::*;
#(
  parameter int INST_W = PE_INST_W,
  parameter int DEPTH  = CTX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ITER_W = CTX_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [INST_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] ctx_last,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              stall,
  input  logic              abort,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, last, last_n, cur, cur_n, rd_addr, pc_adv;
  logic [ITER_W-1:0] iter_left, iter_left_n, iter_eff;
  logic [INST_W-1:0] inst_n, rd_data;
  logic inst_valid_n, done_n;
  // The start edge reads slot 0 directly; during RUN the read port follows pc.
  assign rd_addr  = (state == IDLE) ? '0 : pc;
  assign pc_adv   = (pc == last) ? '0 : pc + ADDR_W'(1);
  assign iter_eff = (iter_cnt == '0) ? ITER_W'(1) : iter_cnt;
  assign busy     = (state != IDLE);
  pe_context_seq_ctx_mem #(.INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (cfg_we && state == IDLE),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      last       <= '0;
      cur        <= '0;
      iter_left  <= '0;
      inst       <= NOP;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      last       <= last_n;
      cur        <= cur_n;
      iter_left  <= iter_left_n;
      inst       <= inst_n;
      inst_valid <= inst_valid_n;
      done       <= done_n;
    end
  // cur is the index now on inst; iter_left counts iterations still owed after it.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    last_n       = last;
    cur_n        = cur;
    iter_left_n  = iter_left;
    inst_n       = inst;
    inst_valid_n = inst_valid;
    done_n       = 1'b0;
    if (state == IDLE) begin
      if (start && !cfg_we) begin
        state_n      = RUN;
        last_n       = ctx_last;
        cur_n        = '0;
        pc_n         = (ctx_last == '0) ? '0 : ADDR_W'(1);
        iter_left_n  = (ctx_last == '0) ? iter_eff - ITER_W'(1) : iter_eff;
        inst_n       = rd_data;
        inst_valid_n = 1'b1;
      end
    end else if (abort) begin
      state_n      = IDLE;
      pc_n         = '0;
      iter_left_n  = '0;
      inst_n       = NOP;
      inst_valid_n = 1'b0;
    end else if (!stall) begin
      if (cur == last && iter_left == '0) begin
        state_n      = IDLE;
        pc_n         = '0;
        inst_n       = NOP;
        inst_valid_n = 1'b0;
        done_n       = 1'b1;
      end else begin
        inst_n      = rd_data;
        cur_n       = pc;
        pc_n        = pc_adv;
        iter_left_n = (pc == last) ? iter_left - ITER_W'(1) : iter_left;
      end
    end
  end
endmodule

// File: tb/tb_pe_context_seq.sv
// tb_pe_context_seq: directed self-checking bench for pe_context_seq
module tb_pe_context_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [47:0] cfg_wdata;
  logic        start;
  logic [3:0]  ctx_last;
  logic [15:0] iter_cnt;
  logic        stall;
  logic        abort;
  logic [47:0] inst;
  logic        inst_valid;
  logic        busy;
  logic        done;
  int checks = 0;
  int errors = 0;
  pe_context_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .ctx_last   (ctx_last),
    .iter_cnt   (iter_cnt),
    .stall      (stall),
    .abort      (abort),
    .inst       (inst),
    .inst_valid (inst_valid),
    .busy       (busy),
    .done       (done)
  );
  always #5 clk = ~clk;
  function automatic logic [47:0] v(input int i);
    return 48'hC0DE_0000_0000 | 48'(i * 17 + 1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_w(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input logic [47:0] ei, input logic ev, input logic eb, input logic ed);
    chk_w({tag, ".inst"}, inst, ei);
    chk_b({tag, ".valid"}, inst_valid, ev);
    chk_b({tag, ".busy"}, busy, eb);
    chk_b({tag, ".done"}, done, ed);
  endtask
  task automatic wr(input logic [3:0] a, input logic [47:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic go(input logic [3:0] l, input logic [15:0] n);
    ctx_last = l;
    iter_cnt = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctx_last = $urandom_range(0, 15);
    iter_cnt = 16'($urandom);
  endtask
  initial begin
    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    start = 1'b0;
    ctx_last = '0;
    iter_cnt = '0;
    stall = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom);
      stall = 1'($urandom);
      abort = 1'($urandom);
      ctx_last = 4'($urandom);
      iter_cnt = 16'($urandom);
      tick();
    end
    st("reset", 48'h0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) wr(4'(i), v(i));
    st("idle_after_cfg", 48'h0, 1'b0, 1'b0, 1'b0);
    go(4'd3, 16'd2);
    for (int k = 0; k < 8; k++) begin
      st("basic", v(k % 4), 1'b1, 1'b1, 1'b0);
      tick();
    end
    st("basic_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    st("basic_after", 48'h0, 1'b0, 1'b0, 1'b0);
    go(4'd3, 16'd1);
    st("stall_a", v(0), 1'b1, 1'b1, 1'b0);
    tick();
    st("stall_b0", v(1), 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      st("stall_bheld", v(1), 1'b1, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick();
    st("stall_c", v(2), 1'b1, 1'b1, 1'b0);
    tick();
    st("stall_d", v(3), 1'b1, 1'b1, 1'b0);
    tick();
    st("stall_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd0, 16'd0);
    st("one_ctx", v(0), 1'b1, 1'b1, 1'b0);
    tick();
    st("one_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd0, 16'd1);
    stall = 1'b1;
    tick();
    st("final_stalled", v(0), 1'b1, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    st("final_released", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd15, 16'd1);
    for (int k = 0; k < 16; k++) begin
      st("all16", v(k), 1'b1, 1'b1, 1'b0);
      tick();
    end
    st("all16_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd1, 16'd3);
    for (int k = 0; k < 6; k++) begin
      st("wrap", v(k % 2), 1'b1, 1'b1, 1'b0);
      tick();
    end
    st("wrap_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd3, 16'd1);
    tick();
    tick();
    st("pre_abort", v(2), 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    st("aborted", 48'h0, 1'b0, 1'b0, 1'b0);
    tick();
    st("aborted_no_done", 48'h0, 1'b0, 1'b0, 1'b0);
    go(4'd3, 16'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    st("mid_reset", 48'h0, 1'b0, 1'b0, 1'b0);
    tick();
    st("mid_reset_no_done", 48'h0, 1'b0, 1'b0, 1'b0);
    go(4'd15, 16'd1);
    for (int k = 0; k < 16; k++) begin
      st("mem_kept", v(k), 1'b1, 1'b1, 1'b0);
      tick();
    end
    st("mem_kept_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd3, 16'd1);
    cfg_we = 1'b1;
    cfg_addr = 4'd2;
    cfg_wdata = 48'hDEAD_BEEF_0002;
    tick();
    cfg_we = 1'b0;
    st("run_wr_b", v(1), 1'b1, 1'b1, 1'b0);
    tick();
    st("run_wr_c", v(2), 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    st("run_wr_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    go(4'd2, 16'd1);
    tick();
    tick();
    st("old_slot2", v(2), 1'b1, 1'b1, 1'b0);
    tick();
    st("old_slot2_done", 48'h0, 1'b0, 1'b0, 1'b1);
    tick();
    cfg_we = 1'b1;
    cfg_addr = 4'd2;
    cfg_wdata = 48'h5EED_0000_0022;
    go(4'd2, 16'd1);
    cfg_we = 1'b0;
    st("start_we_ignored", 48'h0, 1'b0, 1'b0, 1'b0);
    tick();
    st("start_we_still_idle", 48'h0, 1'b0, 1'b0, 1'b0);
    go(4'd2, 16'd1);
    st("new_0", v(0), 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    st("new_slot2", 48'h5EED_0000_0022, 1'b1, 1'b1, 1'b0);
    tick();
    st("new_done", 48'h0, 1'b0, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
